// File: rtl/collision_scheduler.sv
// Once-per-tick collision scan: every shot/asteroid pair, then ship/asteroid pairs,
// one pair per clock through a shared box comparator, on a snapshot taken at start.
module collision_scheduler #(
    parameter int ENTITY_SIZE   = 34,
    parameter int MAX_ASTEROIDS = 3,
    parameter int MAX_SHOTS     = 3,
    parameter int ASTEROID_W    = 16,
    parameter int SHIP_W        = 8,
    localparam int SA_W = (MAX_SHOTS > 1) ? $clog2(MAX_SHOTS) : 1,
    localparam int AA_W = (MAX_ASTEROIDS > 1) ? $clog2(MAX_ASTEROIDS) : 1
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 start,
    input  logic [ENTITY_SIZE-1:0]               ship,
    input  logic [MAX_ASTEROIDS*ENTITY_SIZE-1:0] asteroids,
    input  logic [MAX_SHOTS*ENTITY_SIZE-1:0]     shots,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 delete_shot,
    output logic [SA_W-1:0]                      shot_address,
    output logic                                 kill_asteroid,
    output logic [AA_W-1:0]                      asteroid_address,
    output logic                                 ship_hit,
    output logic [7:0]                           hit_count
);

    localparam int VALID_BIT = 33;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SCAN_SHOTS = 2'd1,
        SCAN_SHIP  = 2'd2,
        DONE       = 2'd3
    } state_t;

    state_t                 r_state, w_state_next;
    logic [ENTITY_SIZE-1:0] r_ship;
    logic [ENTITY_SIZE-1:0] r_ast  [MAX_ASTEROIDS];
    logic [ENTITY_SIZE-1:0] r_shot [MAX_SHOTS];
    logic [ENTITY_SIZE-1:0] w_ast_in  [MAX_ASTEROIDS];
    logic [ENTITY_SIZE-1:0] w_shot_in [MAX_SHOTS];

    logic [SA_W-1:0] r_i, w_i_next;
    logic [AA_W-1:0] r_j, w_j_next;
    logic            r_busy, w_busy_next;
    logic            r_done, w_done_next;
    logic            r_del, w_del_next;
    logic            r_kill, w_kill_next;
    logic            r_ship_hit, w_ship_hit_next;
    logic [SA_W-1:0] r_shot_addr, w_shot_addr_next;
    logic [AA_W-1:0] r_ast_addr, w_ast_addr_next;
    logic [7:0]      r_hit_count, w_hit_count_next;

    logic w_load, w_clr_shot, w_clr_ast, w_clr_ship;

    genvar gi;
    generate
        for (gi = 0; gi < MAX_ASTEROIDS; gi++) begin : g_ast_unpack
            assign w_ast_in[gi] = asteroids[gi*ENTITY_SIZE +: ENTITY_SIZE];
        end
        for (gi = 0; gi < MAX_SHOTS; gi++) begin : g_shot_unpack
            assign w_shot_in[gi] = shots[gi*ENTITY_SIZE +: ENTITY_SIZE];
        end
    endgenerate

    // Shared comparator: a shot is a 1-pixel box (extent 0), the ship an SHIP_W box.
    logic [ENTITY_SIZE-1:0] w_p, w_a;
    logic [10:0]            w_p_ext, w_px, w_py, w_ax, w_ay;
    logic                   w_hit;

    always_comb begin
        w_p     = r_shot[r_i];
        w_p_ext = 11'd0;
        if (r_state == SCAN_SHIP) begin
            w_p     = r_ship;
            w_p_ext = 11'(SHIP_W - 1);
        end
        w_a  = r_ast[r_j];
        w_px = {1'b0, w_p[15:6]};
        w_py = {1'b0, w_p[25:16]};
        w_ax = {1'b0, w_a[15:6]};
        w_ay = {1'b0, w_a[25:16]};
        w_hit = w_p[VALID_BIT] && w_a[VALID_BIT]
             && (w_px <= w_ax + 11'(ASTEROID_W - 1)) && (w_ax <= w_px + w_p_ext)
             && (w_py <= w_ay + 11'(ASTEROID_W - 1)) && (w_ay <= w_py + w_p_ext);
    end

    always_comb begin
        w_state_next     = r_state;
        w_i_next         = r_i;
        w_j_next         = r_j;
        w_busy_next      = r_busy;
        w_done_next      = 1'b0;
        w_del_next       = 1'b0;
        w_kill_next      = 1'b0;
        w_ship_hit_next  = 1'b0;
        w_shot_addr_next = r_shot_addr;
        w_ast_addr_next  = r_ast_addr;
        w_hit_count_next = r_hit_count;
        w_load           = 1'b0;
        w_clr_shot       = 1'b0;
        w_clr_ast        = 1'b0;
        w_clr_ship       = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_load       = 1'b1;
                    w_i_next     = '0;
                    w_j_next     = '0;
                    w_busy_next  = 1'b1;
                    w_state_next = SCAN_SHOTS;
                end
            end
            SCAN_SHOTS: begin
                if (w_hit) begin
                    w_del_next       = 1'b1;
                    w_kill_next      = 1'b1;
                    w_shot_addr_next = r_i;
                    w_ast_addr_next  = r_j;
                    w_clr_shot       = 1'b1;
                    w_clr_ast        = 1'b1;
                    if (r_hit_count != 8'hFF) begin
                        w_hit_count_next = r_hit_count + 8'd1;
                    end
                end
                if (r_j == AA_W'(MAX_ASTEROIDS - 1)) begin
                    w_j_next = '0;
                    if (r_i == SA_W'(MAX_SHOTS - 1)) begin
                        w_i_next     = '0;
                        w_state_next = SCAN_SHIP;
                    end else begin
                        w_i_next = r_i + 1'b1;
                    end
                end else begin
                    w_j_next = r_j + 1'b1;
                end
            end
            SCAN_SHIP: begin
                if (w_hit) begin
                    w_ship_hit_next = 1'b1;
                    w_clr_ship      = 1'b1;
                end
                if (r_j == AA_W'(MAX_ASTEROIDS - 1)) begin
                    w_j_next     = '0;
                    w_state_next = DONE;
                end else begin
                    w_j_next = r_j + 1'b1;
                end
            end
            DONE: begin
                w_done_next  = 1'b1;
                w_busy_next  = 1'b0;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_i         <= '0;
            r_j         <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_del       <= 1'b0;
            r_kill      <= 1'b0;
            r_ship_hit  <= 1'b0;
            r_shot_addr <= '0;
            r_ast_addr  <= '0;
            r_hit_count <= 8'd0;
        end else begin
            r_state     <= w_state_next;
            r_i         <= w_i_next;
            r_j         <= w_j_next;
            r_busy      <= w_busy_next;
            r_done      <= w_done_next;
            r_del       <= w_del_next;
            r_kill      <= w_kill_next;
            r_ship_hit  <= w_ship_hit_next;
            r_shot_addr <= w_shot_addr_next;
            r_ast_addr  <= w_ast_addr_next;
            r_hit_count <= w_hit_count_next;
        end
    end

    // Clearing valid bits in the snapshot is what makes later pairs with a dead entity miss.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_ship <= '0;
            for (int k = 0; k < MAX_ASTEROIDS; k++) r_ast[k] <= '0;
            for (int k = 0; k < MAX_SHOTS; k++) r_shot[k] <= '0;
        end else if (w_load) begin
            r_ship <= ship;
            for (int k = 0; k < MAX_ASTEROIDS; k++) r_ast[k] <= w_ast_in[k];
            for (int k = 0; k < MAX_SHOTS; k++) r_shot[k] <= w_shot_in[k];
        end else begin
            if (w_clr_ship) r_ship[VALID_BIT] <= 1'b0;
            if (w_clr_ast) r_ast[r_j][VALID_BIT] <= 1'b0;
            if (w_clr_shot) r_shot[r_i][VALID_BIT] <= 1'b0;
        end
    end

    assign busy             = r_busy;
    assign done             = r_done;
    assign delete_shot      = r_del;
    assign shot_address     = r_shot_addr;
    assign kill_asteroid    = r_kill;
    assign asteroid_address = r_ast_addr;
    assign ship_hit         = r_ship_hit;
    assign hit_count        = r_hit_count;

endmodule

// File: doc/collision_scheduler.md
# collision_scheduler

Sequences all shot–asteroid and ship–asteroid collision checks once per game tick, one pair per clock, through a single bounding-box comparator. It sits between the entity registers in the top level and the shot controller and asteroid bookkeeping. It issues one-cycle delete and kill strobes with entity addresses, plus a ship-hit strobe. Inputs are snapshotted at start, so entity updates during a scan never corrupt it.

## Interface
- ENTITY_SIZE, 34: entity word width. Fields: [33] valid, [25:16] y, [15:6] x, [5:0] direction.
- MAX_ASTEROIDS, 3: asteroid slots.
- MAX_SHOTS, 3: shot slots.
- ASTEROID_W, 16: asteroid square box edge, in pixels.
- SHIP_W, 8: ship square box edge, in pixels. A shot is a single pixel.
- clk  in  1  system clock.
- reset_n  in  1  reset, synchronous, active-low.
- start  in  1  request a scan; sampled only in IDLE.
- ship  in  ENTITY_SIZE  ship entity word.
- asteroids  in  MAX_ASTEROIDS*ENTITY_SIZE  packed; slot j occupies bits [j*ENTITY_SIZE +: ENTITY_SIZE].
- shots  in  MAX_SHOTS*ENTITY_SIZE  packed; same slot layout as asteroids.
- busy  out  1  high while a scan is in progress.
- done  out  1  one-cycle pulse at scan end.
- delete_shot  out  1  one-cycle strobe: delete the shot at shot_address.
- shot_address  out  clog2(MAX_SHOTS)  index of the shot to delete.
- kill_asteroid  out  1  one-cycle strobe: kill the asteroid at asteroid_address.
- asteroid_address  out  clog2(MAX_ASTEROIDS)  index of the asteroid to kill.
- ship_hit  out  1  one-cycle strobe: ship collided with an asteroid.
- hit_count  out  8  count of asteroid kills; saturates at 255.

## Operation
- States: IDLE, SCAN_SHOTS, SCAN_SHIP, DONE.
- IDLE, start=1:
  - Snapshot ship, asteroids and shots into local registers.
  - Clear indices i and j to 0.
  - Go to SCAN_SHOTS and set busy=1.
- SCAN_SHOTS:
  - Evaluate pair (shot i, asteroid j) each cycle. j is the inner index and i the outer.
  - Hit condition: both snapshot valid bits are set, ax ≤ sx ≤ ax+ASTEROID_W−1, and ay ≤ sy ≤ ay+ASTEROID_W−1.
  - Sums are computed 11 bits wide, with no wrap-around.
  - On hit:
    - Register delete_shot=1 with shot_address=i.
    - Register kill_asteroid=1 with asteroid_address=j.
    - Increment hit_count (saturating).
    - Clear the snapshot valid bits of shot i and asteroid j.
  - The remaining pairs for that shot and asteroid are still visited and evaluate as misses, so each shot kills at most one asteroid and each asteroid dies at most once.
  - After pair (MAX_SHOTS−1, MAX_ASTEROIDS−1), go to SCAN_SHIP with j=0.
- SCAN_SHIP:
  - Evaluate (ship, asteroid j) each cycle, using the post-kill snapshot.
  - Hit condition: ship and asteroid snapshot valid bits are set, and the boxes overlap: sx ≤ ax+ASTEROID_W−1, ax ≤ sx+SHIP_W−1, sy ≤ ay+ASTEROID_W−1, ay ≤ sy+SHIP_W−1.
  - On the first hit, register ship_hit=1 and clear the ship snapshot valid bit, so at most one ship_hit per scan.
  - Ship hits do not kill asteroids.
  - After j=MAX_ASTEROIDS−1, go to DONE.
- DONE: done=1 and busy=0 for one cycle, then return to IDLE.
- start while not in IDLE is ignored; it is not queued.
- Input changes after the snapshot have no effect on the current scan.

## Timing
- Reset (reset_n=0 at a clk edge):
  - State goes to IDLE.
  - busy, done, delete_shot, kill_asteroid and ship_hit are 0.
  - Both addresses are 0 and hit_count is 0.
  - Reset applies mid-scan: no done is emitted and strobes are dropped.
- Fixed latency, with start sampled at edge k:
  - Shot pairs are evaluated at edges k+1 … k+S·A.
  - Ship pairs are evaluated at edges k+S·A+1 … k+S·A+A.
  - done is high after edge k+S·A+A+1 and low after the next edge. With defaults this is 13 cycles after start.
- Strobes are registered: a pair evaluated at edge m produces its strobes for exactly the cycle after edge m.
- Addresses hold their last value between strobes.
- busy is high from edge k+1 through the cycle before done, inclusive; it is low during the done cycle.
- The earliest re-start is sampled in the cycle after done.

## Test plan
1. Reset: hold reset_n=0 for 2 cycles, then release with start=0 → all outputs 0; busy stays 0.
2. Single kill: shot0 valid at (40,10), asteroid0 valid at (32,0), others invalid; pulse start → delete_shot and kill_asteroid high together for 1 cycle, both addresses 0, in the cycle after edge k+1; hit_count=1; done after edge k+13.
3. Box edges: asteroid at (32,0), shot at x=47,y=15 → hit; shot at x=48 or y=16 → no strobe. Asteroid at x=1020 with shot at x=1023 → hit, with no wrap.
4. Uniqueness: shot0 and shot1 both inside asteroid1 → only shot 0 is deleted (one kill). Shot0 inside overlapping asteroids 0 and 2 → only asteroid 0 is killed.
5. Ship:
   - Ship at (0,0), asteroid at (7,7) → one ship_hit in the SCAN_SHIP window (after edge k+10 with defaults).
   - Asteroid at (8,0) → no hit.
   - Ship valid=0 → no hit.
   - Two overlapping asteroids → one ship_hit.
6. Control: start re-pulsed while busy → ignored, single done. reset_n=0 at edge k+5 → IDLE next cycle, no done, hit_count=0.
